// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the RV32M multiply scheduler.
//   - funct3 encodings for MUL/MULH/MULHSU/MULHU
//   - controller state enum
//   - operand sign-class encoding used to tag cached products
package mult_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        FIX    = 3'd3,
        RESP   = 3'd4,
        DRAIN  = 3'd5
    } state_t;

    // {rs1 treated signed, rs2 treated signed}
    typedef enum logic [1:0] {
        CLS_UU = 2'b00,
        CLS_SU = 2'b10,
        CLS_SS = 2'b11
    } sign_cls_t;

    function automatic logic [63:0] neg64(input logic neg, input logic [63:0] v);
        return neg ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/mult_sign_fix.sv
// mult_sign_fix: combinational sign handling around the unsigned multiplier.
//   funct3, rs1, rs2 : request fields
//   sa, sb, neg      : operand sign flags and product negate flag
//   mag_a, mag_b     : operand magnitudes handed to the datapath
//   cls              : sign class of this funct3
//   neg_in, prod_in  : product and negate flag for the result correction
//   prod_out         : sign-corrected 64-bit product
module mult_sign_fix
    import mult_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        neg_in,
    input  logic [63:0] prod_in,
    output logic        sa,
    output logic        sb,
    output logic        neg,
    output logic [31:0] mag_a,
    output logic [31:0] mag_b,
    output sign_cls_t   cls,
    output logic [63:0] prod_out
);

    logic a_signed;
    logic b_signed;

    assign a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU);
    assign b_signed = (funct3 == F3_MULH);

    assign sa    = rs1[31] & a_signed;
    assign sb    = rs2[31] & b_signed;
    assign neg   = sa ^ sb;
    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    assign mag_a = sa ? (~rs1 + 32'd1) : rs1;
    assign mag_b = sb ? (~rs2 + 32'd1) : rs2;

    // class follows the funct3 rule, not the operand values
    assign cls = b_signed ? CLS_SS : (a_signed ? CLS_SU : CLS_UU);

    assign prod_out = neg64(neg_in, prod_in);

endmodule

// File: rtl/mult_sched.sv
// mult_sched: sequencing controller between execute stage and the unsigned
// 32x32 multiplier datapath.
//   req_*      : request handshake (funct3, operands)
//   rsp_*      : result handshake (rd, err)
//   flush      : abort current operation, invalidate product cache
//   mul_*      : datapath launch/operands/completion/product
//   busy       : controller not in IDLE
//
// state  | meaning
// IDLE   | ready for a request
// LAUNCH | one-cycle mul_start pulse
// WAIT   | waiting for mul_done, timeout counter running
// FIX    | sign-correct product, write cache, select half
// RESP   | result presented until rsp_ready
// DRAIN  | flushed; absorb outstanding mul_done or timeout
module mult_sched
    import mult_pkg::*;
#(
    parameter bit CACHE_EN = 1'b1,
    parameter int TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rd,
    output logic        rsp_err,
    input  logic        flush,
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_done,
    input  logic [63:0] mul_prod,
    output logic        busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t      state, state_nx;
    logic [2:0]  f3_q;
    logic        neg_q;
    sign_cls_t   cls_q;
    logic [31:0] rs1_q, rs2_q;
    logic [63:0] prod_q;
    logic [31:0] rd_q;
    logic        err_q;
    logic [CW-1:0] cnt;

    logic        c_valid;
    logic [31:0] c_rs1, c_rs2;
    sign_cls_t   c_cls;
    logic [63:0] c_prod;

    logic        sa, sb, neg;
    logic [31:0] mag_a, mag_b;
    sign_cls_t   cls;
    logic [63:0] prod_fix;

    logic        accept, zero_op, hit, tc;
    logic [31:0] hit_rd, fix_rd;

    mult_sign_fix u_sign (
        .funct3   (req_funct3),
        .rs1      (req_rs1),
        .rs2      (req_rs2),
        .neg_in   (neg_q),
        .prod_in  (prod_q),
        .sa       (sa),
        .sb       (sb),
        .neg      (neg),
        .mag_a    (mag_a),
        .mag_b    (mag_b),
        .cls      (cls),
        .prod_out (prod_fix)
    );

    // individual sign flags are folded into neg; kept for observability only
    logic unused_sign_flags;
    assign unused_sign_flags = sa & sb;

    assign accept  = req_valid & req_ready;
    assign zero_op = (req_rs1 == 32'd0) || (req_rs2 == 32'd0);
    // low word of the product does not depend on sign class
    assign hit     = CACHE_EN && c_valid && (c_rs1 == req_rs1) && (c_rs2 == req_rs2)
                     && ((req_funct3 == F3_MUL) || (c_cls == cls));
    assign tc      = (cnt >= CW'(TIMEOUT - 1));
    assign hit_rd  = (req_funct3 == F3_MUL) ? c_prod[31:0] : c_prod[63:32];
    assign fix_rd  = (f3_q == F3_MUL) ? prod_fix[31:0] : prod_fix[63:32];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (accept) state_nx = (req_funct3[2] || zero_op || hit) ? RESP : LAUNCH;
            LAUNCH: state_nx = flush ? DRAIN : WAIT;
            WAIT: begin
                if (flush)         state_nx = DRAIN;
                else if (mul_done) state_nx = FIX;
                else if (tc)       state_nx = RESP;
            end
            FIX:    state_nx = flush ? IDLE : RESP;
            RESP:   if (flush || rsp_ready) state_nx = IDLE;
            DRAIN:  if (mul_done || tc) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE) && !flush;
        rsp_valid = (state == RESP) && !flush;
        mul_start = (state == LAUNCH);
        busy      = (state != IDLE);
    end

    assign rsp_rd  = rd_q;
    assign rsp_err = err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            f3_q   <= F3_MUL;
            neg_q  <= 1'b0;
            cls_q  <= CLS_UU;
            rs1_q  <= '0;
            rs2_q  <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
            prod_q <= '0;
            rd_q   <= '0;
            err_q  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    f3_q  <= req_funct3;
                    neg_q <= neg;
                    cls_q <= cls;
                    rs1_q <= req_rs1;
                    rs2_q <= req_rs2;
                    mul_a <= mag_a;
                    mul_b <= mag_b;
                    err_q <= req_funct3[2];
                    if (req_funct3[2] || zero_op) rd_q <= '0;
                    else if (hit)                 rd_q <= hit_rd;
                end
                LAUNCH: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (mul_done) begin
                        prod_q <= mul_prod;
                    end else if (tc) begin
                        rd_q  <= '0;
                        err_q <= 1'b1;
                    end
                end
                FIX: begin
                    rd_q  <= fix_rd;
                    err_q <= 1'b0;
                end
                DRAIN: cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // a FIX-cycle write lands even when flush arrives alongside it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            c_valid <= 1'b0;
            c_rs1   <= '0;
            c_rs2   <= '0;
            c_cls   <= CLS_UU;
            c_prod  <= '0;
        end else if (state == FIX && CACHE_EN) begin
            c_valid <= 1'b1;
            c_rs1   <= rs1_q;
            c_rs2   <= rs2_q;
            c_cls   <= cls_q;
            c_prod  <= prod_fix;
        end else if (flush) begin
            c_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mult_sched.sv
module tb_mult_sched;

    localparam int TIMEOUT = 64;
    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_rs1 = 32'd0;
    logic [31:0] req_rs2 = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rd;
    logic        rsp_err;
    logic        flush = 1'b0;
    logic        mul_start;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_done = 1'b0;
    logic [63:0] mul_prod = 64'd0;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    mult_sched #(.CACHE_EN(1'b1), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
        .flush(flush),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_prod(mul_prod),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_valid = 0;
    logic [31:0] m_a = 0, m_b = 0;
    int          m_cls = 0;

    function automatic int cls_of(input logic [2:0] f3);
        if (f3 == MULH)   return 2;
        if (f3 == MULHSU) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] model_rd(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] x, y, p;
        x = (f3 == MULH || f3 == MULHSU) ? $signed({{34{a[31]}}, a}) : $signed({34'd0, a});
        y = (f3 == MULH) ? $signed({{34{b[31]}}, b}) : $signed({34'd0, b});
        p = x * y;
        return (f3 == MUL) ? p[31:0] : p[63:32];
    endfunction

    // ---------------- datapath model ----------------
    int          dp_lat = 0;
    int          k = 0;
    int          starts = 0;
    logic [31:0] pa = 0, pb = 0;
    bit          held = 0;

    initial begin
        forever begin
            @(negedge clk);
            mul_done = 1'b0;
            if (!rstn) held = 0;
            if (k > 0) begin
                if (held) begin
                    chk("mul_a_held", 64'(mul_a), 64'(pa));
                    chk("mul_b_held", 64'(mul_b), 64'(pb));
                end
                k--;
                if (k == 0) begin
                    mul_done = 1'b1;
                    mul_prod = 64'(pa) * 64'(pb);
                    held = 0;
                end
            end
            if (rstn && mul_start) begin
                starts++;
                pa = mul_a;
                pb = mul_b;
                k = dp_lat;
                held = 1;
            end
        end
    end

    // ---------------- response compare ----------------
    bit          exp_on = 0;
    logic [31:0] exp_rd = 0;
    logic        exp_err = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (exp_on) begin
                    if (rsp_valid) begin
                        chk("rsp_rd", 64'(rsp_rd), 64'(exp_rd));
                        chk("rsp_err", 64'(rsp_err), 64'(exp_err));
                    end
                end else begin
                    chk("no_rsp_valid", 64'(rsp_valid), 64'd0);
                end
            end
        end
    end

    task automatic wait_ready();
        int guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready_before", 64'(req_ready), 64'd1);
    endtask

    task automatic run_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input int lat, input int bp,
                           output logic [31:0] rd_o, output logic err_o, output int lat_o, output int st_o);
        bit hit, zero, miss;
        int exp_lat;
        wait_ready();
        zero    = (a == 0) || (b == 0);
        hit     = m_valid && (m_a == a) && (m_b == b) && (f3 == MUL || m_cls == cls_of(f3));
        miss    = !f3[2] && !zero && !hit;
        exp_err = f3[2] || (miss && lat == 0);
        exp_rd  = (exp_err || zero) ? 32'd0 : model_rd(f3, a, b);
        exp_lat = !miss ? 1 : ((lat == 0) ? 2 + TIMEOUT : 3 + lat);
        starts  = 0;
        dp_lat  = lat;
        req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b;
        exp_on = 1;
        @(negedge clk);
        req_valid = 1'b0;
        lat_o = 1;
        while (!rsp_valid && lat_o < 200) begin
            @(negedge clk);
            lat_o++;
        end
        chk("rsp_latency", 64'(lat_o), 64'(exp_lat));
        rd_o  = rsp_rd;
        err_o = rsp_err;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_rd_stable", 64'(rsp_rd), 64'(rd_o));
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_hs_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("post_hs_req_ready", 64'(req_ready), 64'd1);
        exp_on = 0;
        st_o = starts;
        chk("mul_start_count", 64'(starts), 64'(miss));
        if (miss && lat != 0) begin
            m_valid = 1; m_a = a; m_b = b; m_cls = cls_of(f3);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lt, st;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rd", 64'(rsp_rd), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_mul_start", 64'(mul_start), 64'd0);
        chk("rst_mul_a", 64'(mul_a), 64'd0);
        chk("rst_mul_b", 64'(mul_b), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        // MULHU max x max, latency 17
        run_req(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 17, 0, rd, err, lt, st);
        chk("pin_mulhu_rd", 64'(rd), 64'hFFFFFFFE);
        chk("pin_mulhu_err", 64'(err), 64'd0);
        chk("pin_mulhu_lat", 64'(lt), 64'd20);
        chk("pin_mulhu_starts", 64'(st), 64'd1);
        chk("pin_mulhu_a", 64'(pa), 64'hFFFFFFFF);
        chk("pin_mulhu_b", 64'(pb), 64'hFFFFFFFF);

        // MULH min x min, then MUL hit
        run_req(MULH, 32'h80000000, 32'h80000000, 5, 0, rd, err, lt, st);
        chk("pin_mulh_rd", 64'(rd), 64'h40000000);
        chk("pin_mulh_a", 64'(pa), 64'h80000000);
        chk("pin_mulh_lat", 64'(lt), 64'd8);
        run_req(MUL, 32'h80000000, 32'h80000000, 5, 0, rd, err, lt, st);
        chk("pin_mul_hit_rd", 64'(rd), 64'd0);
        chk("pin_mul_hit_lat", 64'(lt), 64'd1);
        chk("pin_mul_hit_starts", 64'(st), 64'd0);

        // MULHSU then MULHU same operands (class miss), with backpressure
        run_req(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 4, 0, rd, err, lt, st);
        chk("pin_mulhsu_rd", 64'(rd), 64'hFFFFFFFF);
        chk("pin_mulhsu_a", 64'(pa), 64'h1);
        chk("pin_mulhsu_b", 64'(pb), 64'hFFFFFFFF);
        run_req(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, 5, rd, err, lt, st);
        chk("pin_class_miss_starts", 64'(st), 64'd1);
        chk("pin_class_miss_rd", 64'(rd), 64'hFFFFFFFE);
        chk("pin_class_miss_lat", 64'(lt), 64'd6);

        // zero operand and illegal funct3 shortcuts
        run_req(MUL, 32'h12345678, 32'h0, 5, 0, rd, err, lt, st);
        chk("pin_zero_rd", 64'(rd), 64'd0);
        chk("pin_zero_lat", 64'(lt), 64'd1);
        chk("pin_zero_starts", 64'(st), 64'd0);
        run_req(3'b100, 32'd5, 32'd7, 5, 0, rd, err, lt, st);
        chk("pin_illegal_rd", 64'(rd), 64'd0);
        chk("pin_illegal_err", 64'(err), 64'd1);
        chk("pin_illegal_lat", 64'(lt), 64'd1);

        // MUL hit on an entry written by MULHU
        run_req(MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 0, rd, err, lt, st);
        chk("pin_mul_uu_hit_rd", 64'(rd), 64'd1);
        chk("pin_mul_uu_hit_lat", 64'(lt), 64'd1);

        // flush in IDLE blocks acceptance and invalidates the cache
        wait_ready();
        req_valid = 1'b1; req_funct3 = MUL; req_rs1 = 32'd3; req_rs2 = 32'd4; flush = 1'b1;
        #1 chk("idle_flush_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        chk("idle_flush_busy", 64'(busy), 64'd0);
        m_valid = 0;

        // flush 3 cycles after mul_start -> DRAIN until mul_done
        wait_ready();
        starts = 0; dp_lat = 10;
        req_valid = 1'b1; req_funct3 = MUL; req_rs1 = 32'd3; req_rs2 = 32'd5;
        @(negedge clk);
        req_valid = 1'b0;
        chk("flush_mul_start", 64'(mul_start), 64'd1);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("drain_busy", 64'(busy), 64'd1);
        chk("drain_req_ready", 64'(req_ready), 64'd0);
        for (int c = 6; c <= 11; c++) begin
            @(negedge clk);
            chk("drain_busy", 64'(busy), 64'd1);
        end
        @(negedge clk);
        chk("drain_exit_busy", 64'(busy), 64'd0);
        chk("drain_exit_req_ready", 64'(req_ready), 64'd1);
        m_valid = 0;
        run_req(MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 0, rd, err, lt, st);
        chk("pin_after_flush_starts", 64'(st), 64'd1);
        chk("pin_after_flush_rd", 64'(rd), 64'd1);
        chk("pin_after_flush_lat", 64'(lt), 64'd5);

        // reset mid-operation; late mul_done must be ignored
        wait_ready();
        starts = 0; dp_lat = 6;
        req_valid = 1'b1; req_funct3 = MULHU; req_rs1 = 32'd7; req_rs2 = 32'd9;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_mid_start", 64'(mul_start), 64'd1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_mul_a", 64'(mul_a), 64'd0);
        chk("rst_mid_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        m_valid = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("rst_late_done_busy", 64'(busy), 64'd0);
        end

        // datapath never returns -> timeout error, no cache write
        run_req(MULHU, 32'h80000000, 32'd4, 0, 0, rd, err, lt, st);
        chk("pin_timeout_err", 64'(err), 64'd1);
        chk("pin_timeout_rd", 64'(rd), 64'd0);
        chk("pin_timeout_lat", 64'(lt), 64'(2 + TIMEOUT));
        run_req(MULHU, 32'h80000000, 32'd4, 2, 0, rd, err, lt, st);
        chk("pin_retry_starts", 64'(st), 64'd1);
        chk("pin_retry_rd", 64'(rd), 64'd2);
        run_req(MULHU, 32'h80000000, 32'd4, 2, 0, rd, err, lt, st);
        chk("pin_retry_hit_lat", 64'(lt), 64'd1);
        chk("pin_retry_hit_rd", 64'(rd), 64'd2);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_sched.md
Name: mult_sched

Overview:
- Sequencing controller between the core's execute stage and the unsigned 32x32 multiplier datapath.
- Accepts RV32M multiply requests (MUL/MULH/MULHSU/MULHU) over a valid/ready handshake and converts signed operands to magnitudes.
- Launches the datapath, waits for completion, sign-corrects the 64-bit product, selects the half required by funct3, and returns the result over a valid/ready handshake.
- Holds a one-entry product cache and a zero-operand shortcut so repeated or trivial multiplies skip the datapath.

Parameters:
- CACHE_EN, 1: enables the one-entry product cache; 0 forces every nonzero request to the datapath.
- TIMEOUT, 64: maximum cycles in WAIT before mul_done must arrive; counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request valid.
- req_ready  out  1  controller can accept a request.
- req_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
- req_rs1  in  32  operand A.
- req_rs2  in  32  operand B.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_rd  out  32  result.
- rsp_err  out  1  timeout or illegal funct3; qualified by rsp_valid.
- flush  in  1  abort the current operation.
- mul_start  out  1  one-cycle launch pulse to the datapath.
- mul_a  out  32  magnitude of A; held stable from mul_start until mul_done.
- mul_b  out  32  magnitude of B; held stable from mul_start until mul_done.
- mul_done  in  1  one-cycle completion pulse from the datapath.
- mul_prod  in  64  unsigned product; valid when mul_done=1.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rstn=0, async):
  - State goes to IDLE; cache invalid; timeout counter cleared.
  - Outputs: req_ready=1, rsp_valid=0, rsp_rd=0, rsp_err=0, mul_start=0, mul_a=0, mul_b=0, busy=0.
  - Reset mid-operation discards all work; a late mul_done is ignored.
- States: IDLE, LAUNCH, WAIT, FIX, RESP, DRAIN.
- Accept: a request is accepted when req_valid & req_ready. req_ready=1 only in IDLE.
- At accept, latch funct3 and operands, and compute:
  - sa = rs1[31] & (funct3 is MULH or MULHSU).
  - sb = rs2[31] & (funct3 is MULH).
  - neg = sa ^ sb.
  - mul_a = sa ? -rs1 : rs1; mul_b = sb ? -rs2 : rs2 (32-bit two's complement; magnitude of 0x80000000 is 0x80000000 unsigned).
- IDLE transitions on accept, in priority order:
  1. funct3[2]=1: go to RESP with rd=0, rsp_err=1.
  2. rs1==0 or rs2==0: go to RESP with rd=0.
  3. Cache hit: go to RESP with the result taken from the cached signed product.
  4. Otherwise: go to LAUNCH.
- Cache hit condition: valid & cached rs1==rs1 & cached rs2==rs2 & (funct3==MUL or cached sign class==this sign class).
  - Sign class is {sa-rule, sb-rule}: SS, SU or UU.
  - MUL hits regardless of sign class because the low 32 bits are class-independent.
- LAUNCH: mul_start=1 for exactly one cycle, then go to WAIT. The timeout counter clears.
- WAIT:
  - Counter increments each cycle.
  - mul_done: register mul_prod and go to FIX.
  - Counter reaches TIMEOUT without mul_done: go to RESP with rd=0, rsp_err=1; cache is not written.
- FIX:
  - P = neg ? -mul_prod : mul_prod (64-bit).
  - Write the cache with {rs1, rs2, sign class, P}.
  - rd = funct3==MUL ? P[31:0] : P[63:32]. Go to RESP.
- RESP: rsp_valid=1, with rsp_rd and rsp_err held stable until rsp_ready. On rsp_ready, go to IDLE.
  - req_ready rises the cycle after the handshake; there is no same-cycle back-to-back accept.
- Latency from accept to first rsp_valid:
  - Shortcut, cache hit or illegal funct3: 1 cycle.
  - Datapath miss: 3 + datapath latency (LAUNCH, WAIT for N cycles, FIX).
- flush:
  - In LAUNCH or WAIT: go to DRAIN.
  - In FIX or RESP: drop the result and go to IDLE. The cache write from FIX still completes.
  - In IDLE: no effect; a request offered in the same cycle is not accepted.
- DRAIN: req_ready=0. Wait for mul_done or timeout, discard the result, go to IDLE.
- mul_done outside WAIT and DRAIN is ignored.
- The cache is invalidated by rstn and by flush in any state.

Decomposition:
- mult_pkg holds:
  - funct3 constants F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU.
  - state enum: IDLE, LAUNCH, WAIT, FIX, RESP, DRAIN.
  - sign class encoding: SS, SU, UU.
- Sub-module mult_sign_fix (combinational):
  - Inputs: funct3, rs1, rs2.
  - Outputs: sa, sb, neg, magnitude A, magnitude B, sign class.
  - Also provides a 64-bit conditional negate.
  - Shared between operand entry and the FIX stage.

Test Plan:
- MULHU 0xFFFFFFFF x 0xFFFFFFFF, datapath latency 17 -> one mul_start, mul_a=mul_b=0xFFFFFFFF, rsp_rd=0xFFFFFFFE, rsp_err=0, rsp_valid 20 cycles after accept.
- MULH 0x80000000 x 0x80000000 -> rd=0x40000000. Then MUL with the same operands -> cache hit, no mul_start, rd=0x00000000, rsp_valid 1 cycle after accept.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> mul_a=0x00000001, neg=1, rd=0xFFFFFFFF. Then MULHU with the same operands -> cache miss (class differs), mul_start pulses, rd=0xFFFFFFFE.
- MUL 0x12345678 x 0 -> no mul_start, rd=0, 1-cycle latency. funct3=100 -> rd=0, rsp_err=1.
- Backpressure: rsp_ready held 0 for 5 cycles -> rsp_rd stable, req_ready=0 throughout. Handshake, then req_ready=1 the next cycle.
- flush 3 cycles after mul_start -> DRAIN, busy=1 until mul_done, no rsp_valid, cache invalid. Datapath never returning mul_done -> rsp_err=1 after TIMEOUT=64 WAIT cycles.
